// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA text renderer.
package vga_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 30;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // One character-buffer entry as written by the CPU.
    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] code;
    } char_cell_t;

    // 16-colour CGA palette, 12'hRGB.
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    // Built-in glyph set: NUL and space are empty, 8'hDB is the full
    // block, every other code gets a row-dependent pattern.
    function automatic logic [7:0] glyph_bits(input logic [7:0] code,
                                              input logic [3:0] row);
        logic [7:0] bits;
        bits = code ^ {row, row};
        if (code == 8'h00 || code == 8'h20) bits = 8'h00;
        if (code == 8'hDB) bits = 8'hFF;
        return bits;
    endfunction

endpackage

// File: rtl/vga_font_rom.sv
// 4096x8 synchronous-read font ROM addressed by {code, glyph_row}.
// Contents come from the glyph generator in vga_pkg so the block is
// self-contained; MSB of the data is the leftmost pixel.
module vga_font_rom
    import vga_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_en,
    input  logic [11:0] i_addr,
    output logic [7:0]  o_data
);

    // Registered read, advancing only with the pixel strobe.
    always_ff @(posedge i_clk) begin
        if (i_en) o_data <= glyph_bits(i_addr[11:4], i_addr[3:0]);
    end

endmodule

// File: rtl/vga_text_renderer.sv
// Four-stage text-mode pixel pipeline: cell address, character buffer
// read, font read, palette/cursor/blank. Side-band follows the pixel.
module vga_text_renderer
    import vga_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int BLINK_BIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_stb,
    input  logic        i_hs_in,
    input  logic        i_vs_in,
    input  logic        i_blanking_in,
    input  logic [9:0]  i_x,
    input  logic [8:0]  i_y,
    input  logic        i_wr_en,
    input  logic [11:0] i_wr_addr,
    input  logic [15:0] i_wr_data,
    input  logic        i_cursor_en,
    input  logic [11:0] i_cursor_addr,
    output logic [3:0]  o_r,
    output logic [3:0]  o_g,
    output logic [3:0]  o_b,
    output logic        o_hs_out,
    output logic        o_vs_out,
    output logic        o_blank_out
);

    localparam int CELLS = COLS * ROWS;

    // Cell index for an 80-column grid: row*80 = (row<<6)+(row<<4).
    logic [11:0] w_row, w_col, w_cell;
    assign w_row  = {7'd0, i_y[8:4]};
    assign w_col  = {5'd0, i_x[9:3]};
    assign w_cell = (w_row << 6) + (w_row << 4) + w_col;

    logic [11:0] r1_cell;
    logic [3:0]  r1_grow, r2_grow, r3_grow;
    logic [2:0]  r1_bsel, r2_bsel, r3_bsel;
    logic        r1_hs, r2_hs, r3_hs;
    logic        r1_vs, r2_vs, r3_vs;
    logic        r1_blank, r2_blank, r3_blank;
    logic        r1_hit, r2_hit, r3_hit;
    logic [3:0]  r3_fg, r3_bg;
    logic [4:0]  r_frame;
    logic        r_vs_prev;

    char_cell_t  r_mem [CELLS];
    char_cell_t  r2_cell;
    logic [7:0]  w_font;

    // S1: address and cursor match, capture pixel-local coordinates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r1_cell  <= '0;
            r1_grow  <= '0;
            r1_bsel  <= '0;
            r1_hs    <= 1'b1;
            r1_vs    <= 1'b1;
            r1_blank <= 1'b1;
            r1_hit   <= 1'b0;
        end else if (i_pix_stb) begin
            r1_cell  <= w_cell;
            r1_grow  <= i_y[3:0];
            r1_bsel  <= i_x[2:0];
            r1_hs    <= i_hs_in;
            r1_vs    <= i_vs_in;
            r1_blank <= i_blanking_in;
            r1_hit   <= (w_cell == i_cursor_addr);
        end
    end

    // Character buffer: CPU writes anytime, S2 read is read-first.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && (i_wr_addr < 12'(CELLS))) r_mem[i_wr_addr] <= char_cell_t'(i_wr_data);
        if (i_pix_stb) r2_cell <= r_mem[r1_cell];
    end

    // S2: side-band delay alongside the buffer read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r2_grow  <= '0;
            r2_bsel  <= '0;
            r2_hs    <= 1'b1;
            r2_vs    <= 1'b1;
            r2_blank <= 1'b1;
            r2_hit   <= 1'b0;
        end else if (i_pix_stb) begin
            r2_grow  <= r1_grow;
            r2_bsel  <= r1_bsel;
            r2_hs    <= r1_hs;
            r2_vs    <= r1_vs;
            r2_blank <= r1_blank;
            r2_hit   <= r1_hit;
        end
    end

    vga_font_rom u_font (
        .i_clk  (i_clk),
        .i_en   (i_pix_stb),
        .i_addr ({r2_cell.code, r2_grow}),
        .o_data (w_font)
    );

    // S3: side-band and attribute delay alongside the font read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r3_grow  <= '0;
            r3_bsel  <= '0;
            r3_hs    <= 1'b1;
            r3_vs    <= 1'b1;
            r3_blank <= 1'b1;
            r3_hit   <= 1'b0;
            r3_fg    <= '0;
            r3_bg    <= '0;
        end else if (i_pix_stb) begin
            r3_grow  <= r2_grow;
            r3_bsel  <= r2_bsel;
            r3_hs    <= r2_hs;
            r3_vs    <= r2_vs;
            r3_blank <= r2_blank;
            r3_hit   <= r2_hit;
            r3_fg    <= r2_cell.fg;
            r3_bg    <= r2_cell.bg;
        end
    end

    // S4 combinational: bit select, cursor underline inversion, palette.
    logic        w_inv, w_pix;
    logic [11:0] w_rgb;
    assign w_inv = i_cursor_en & r3_hit & r_frame[BLINK_BIT] & (r3_grow >= 4'd14);
    assign w_pix = w_font[~r3_bsel] ^ w_inv;
    assign w_rgb = PALETTE[w_pix ? r3_fg : r3_bg];

    // S4: registered DAC outputs, black while blanked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {o_r, o_g, o_b} <= 12'h000;
            o_hs_out        <= 1'b1;
            o_vs_out        <= 1'b1;
            o_blank_out     <= 1'b1;
        end else if (i_pix_stb) begin
            {o_r, o_g, o_b} <= r3_blank ? 12'h000 : w_rgb;
            o_hs_out        <= r3_hs;
            o_vs_out        <= r3_vs;
            o_blank_out     <= r3_blank;
        end
    end

    // Frame counter: counts vs_in falling edges seen on pixel strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame   <= '0;
            r_vs_prev <= 1'b1;
        end else if (i_pix_stb) begin
            r_vs_prev <= i_vs_in;
            if (r_vs_prev && !i_vs_in) r_frame <= r_frame + 5'd1;
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: constant vector table, hand sequences for
// cursor blink and stalls, and a randomized run against a pixel model.
module tb_vga_text_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pix_stb, hs_in, vs_in, blank_in, wr_en, cursor_en;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] wr_addr, cursor_addr;
    logic [15:0] wr_data;
    logic [3:0]  r, g, b;
    logic        hs_out, vs_out, blank_out;

    vga_text_renderer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb),
        .i_hs_in(hs_in), .i_vs_in(vs_in), .i_blanking_in(blank_in),
        .i_x(x), .i_y(y), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_cursor_en(cursor_en),
        .i_cursor_addr(cursor_addr), .o_r(r), .o_g(g), .o_b(b),
        .o_hs_out(hs_out), .o_vs_out(vs_out), .o_blank_out(blank_out)
    );

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        hs, vs, bl;
        logic [11:0] cur;
        logic [15:0] data;
    } req_t;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        bl;
        logic [11:0] exp;
    } vec_t;

    logic [11:0] pal [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA,
                              12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                              12'h555, 12'h55F, 12'h5F5, 12'h5FF,
                              12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

    logic [15:0] m_buf [2400];
    req_t        s1, s2, s3;
    int          m_frame;
    logic        m_vs_prev;
    logic [11:0] e_rgb;
    logic        e_hs, e_vs, e_bl;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [7:0] font_ref(input logic [7:0] c, input logic [3:0] row);
        if (c == 8'h00 || c == 8'h20) return 8'h00;
        if (c == 8'hDB) return 8'hFF;
        return c ^ 8'(int'(row) * 17);
    endfunction

    function automatic int cell_of(input logic [9:0] xx, input logic [8:0] yy);
        return (int'(yy) / 16) * 80 + int'(xx) / 8;
    endfunction

    function automatic logic [11:0] pixel_ref(input req_t q, input int frame, input logic cen);
        int gr, xb;
        logic [7:0] f;
        logic p;
        if (q.bl) return 12'h000;
        gr = int'(q.y) % 16;
        xb = int'(q.x) % 8;
        f  = font_ref(q.data[7:0], 4'(gr));
        p  = f[7 - xb];
        if (cen && cell_of(q.x, q.y) == int'(q.cur) && frame >= 16 && gr >= 14) p = ~p;
        return p ? pal[q.data[11:8]] : pal[q.data[15:12]];
    endfunction

    function automatic req_t idle_req();
        req_t q;
        q.x = '0; q.y = '0; q.hs = 1'b1; q.vs = 1'b1; q.bl = 1'b1;
        q.cur = '0; q.data = '0;
        return q;
    endfunction

    // Advance the model by one clock edge, using the values the DUT saw.
    task automatic model_edge();
        int c;
        if (!rst_n) begin
            s1 = idle_req(); s2 = idle_req(); s3 = idle_req();
            m_frame = 0; m_vs_prev = 1'b1;
            e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1;
        end else if (pix_stb) begin
            e_rgb = pixel_ref(s3, m_frame, cursor_en);
            e_hs = s3.hs; e_vs = s3.vs; e_bl = s3.bl;
            s3 = s2;
            s2 = s1;
            c = cell_of(s1.x, s1.y);
            s2.data = (c < 2400) ? m_buf[c] : 16'h0000;
            s1.x = x; s1.y = y; s1.hs = hs_in; s1.vs = vs_in; s1.bl = blank_in;
            s1.cur = cursor_addr; s1.data = '0;
            if (m_vs_prev && !vs_in) m_frame = (m_frame + 1) % 32;
            m_vs_prev = vs_in;
        end
        if (wr_en && int'(wr_addr) < 2400) m_buf[wr_addr] = wr_data;
    endtask

    task automatic step(input logic stb, input logic [9:0] xi, input logic [8:0] yi,
                        input logic hsi, input logic vsi, input logic bli,
                        input logic we, input logic [11:0] wa, input logic [15:0] wd);
        pix_stb = stb; x = xi; y = yi; hs_in = hsi; vs_in = vsi; blank_in = bli;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model(input string nm);
        checks++;
        if ({r, g, b, hs_out, vs_out, blank_out} !== {e_rgb, e_hs, e_vs, e_bl}) begin
            errors++;
            $display("FAIL %s: got rgb=%h hs=%b vs=%b bl=%b, want rgb=%h hs=%b vs=%b bl=%b",
                     nm, {r, g, b}, hs_out, vs_out, blank_out, e_rgb, e_hs, e_vs, e_bl);
        end
    endtask

    task automatic chk_val(input string nm, input logic [14:0] got, input logic [14:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        step(1'b0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12'(a), d);
    endtask

    task automatic vs_pulse();
        step(1'b1, 10'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 16'd0);
        step(1'b1, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 16'd0);
    endtask

    // Push one pixel (hs low) then flush; result is on the outputs after.
    task automatic show(input logic [9:0] xi, input logic [8:0] yi, input logic bli);
        step(1'b1, xi, yi, 1'b0, 1'b1, bli, 1'b0, 12'd0, 16'd0);
        step(1'b1, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 16'd0);
        step(1'b1, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 16'd0);
        chk_val("lat3_still_blank", {14'd0, blank_out}, 15'd1);
        step(1'b1, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 16'd0);
        chk_model("show_model");
    endtask

    task automatic show_exp(input string nm, input logic [9:0] xi, input logic [8:0] yi,
                            input logic [11:0] want);
        show(xi, yi, 1'b0);
        chk_val(nm, {3'd0, r, g, b}, {3'd0, want});
    endtask

    vec_t tv [10];

    initial begin
        tv[0] = '{10'd0,   9'd0,   1'b0, 12'hFFF};
        tv[1] = '{10'd7,   9'd15,  1'b0, 12'hFFF};
        tv[2] = '{10'd632, 9'd464, 1'b0, 12'hA00};
        tv[3] = '{10'd639, 9'd479, 1'b0, 12'hA00};
        tv[4] = '{10'd635, 9'd470, 1'b0, 12'hA00};
        tv[5] = '{10'd0,   9'd0,   1'b1, 12'h000};
        tv[6] = '{10'd41,  9'd0,   1'b0, 12'hFF5};
        tv[7] = '{10'd40,  9'd0,   1'b0, 12'h0A0};
        tv[8] = '{10'd47,  9'd1,   1'b0, 12'h0A0};
        tv[9] = '{10'd43,  9'd1,   1'b0, 12'hFF5};

        rst_n = 1'b0; cursor_en = 1'b0; cursor_addr = '0;
        pix_stb = 1'b0; x = '0; y = '0; hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset held with strobes toggling and arbitrary inputs.
        for (int i = 0; i < 8; i++) begin
            step(1'(i % 2), 10'($urandom_range(0, 639)), 9'($urandom_range(0, 479)),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 12'd0, 16'd0);
            chk_val("reset_outputs", {r, g, b, hs_out, vs_out, blank_out}, 15'h0007);
        end
        rst_n = 1'b1;

        // Fill the whole buffer so the model knows every cell.
        for (int i = 0; i < 2400; i++) wr(i, 16'($urandom));
        wr(0, 16'h1FDB);
        wr(2399, 16'h4700);
        wr(5, 16'h2E41);

        // Table vectors: one pixel, fixed expected colour 4 strobes later.
        for (int i = 0; i < 10; i++) begin
            show(tv[i].x, tv[i].y, tv[i].bl);
            chk_val($sformatf("vec%0d_rgb", i), {3'd0, r, g, b}, {3'd0, tv[i].exp});
            chk_val($sformatf("vec%0d_sync", i), {13'd0, hs_out, blank_out}, {13'd0, 1'b0, tv[i].bl});
        end

        // Out-of-range write must not disturb any cell.
        wr(2400, 16'hFFFF);
        show_exp("oob_cell2399", 10'd639, 9'd479, 12'hA00);
        show_exp("oob_cell0", 10'd0, 9'd0, 12'hFFF);

        // Cursor blink: restart frame count, cell 0 empty glyph fg15 bg0.
        rst_n = 1'b0;
        step(1'b0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 16'd0);
        rst_n = 1'b1;
        wr(0, 16'h0F00);
        cursor_en = 1'b1; cursor_addr = 12'd0;
        show_exp("cur_f0", 10'd0, 9'd14, 12'h000);
        for (int i = 0; i < 15; i++) vs_pulse();
        show_exp("cur_f15", 10'd0, 9'd15, 12'h000);
        vs_pulse();
        show_exp("cur_f16_r14", 10'd0, 9'd14, 12'hFFF);
        show_exp("cur_f16_r15", 10'd7, 9'd15, 12'hFFF);
        show_exp("cur_f16_r13", 10'd0, 9'd13, 12'h000);
        cursor_en = 1'b0;
        show_exp("cur_disabled", 10'd0, 9'd14, 12'h000);
        cursor_en = 1'b1;
        for (int i = 0; i < 16; i++) vs_pulse();
        show_exp("cur_f32", 10'd0, 9'd15, 12'h000);
        cursor_en = 1'b0;

        // Stall for 3 cycles mid-line; outputs must hold then resume.
        for (int i = 0; i < 20; i++) begin
            step(!(i >= 8 && i < 11), 10'(i * 3), 9'd100, 1'(i % 5 != 0), 1'b1, 1'b0,
                 1'b0, 12'd0, 16'd0);
            chk_model("stall");
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 16'd0);
            chk_model("stall_flush");
        end

        // Randomized traffic, writes racing reads, cursor on live pixels.
        for (int i = 0; i < 4000; i++) begin
            logic [9:0]  rx;
            logic [8:0]  ry;
            logic [11:0] wa;
            rx = 10'($urandom_range(0, 639));
            ry = 9'($urandom_range(0, 479));
            cursor_en = 1'($urandom);
            cursor_addr = ($urandom_range(0, 1) == 0) ? 12'(cell_of(rx, ry))
                                                      : 12'($urandom_range(0, 2399));
            wa = ($urandom_range(0, 2) == 0) ? 12'(cell_of(s1.x, s1.y))
                                             : 12'($urandom_range(0, 2499));
            step(1'($urandom_range(0, 3) != 0), rx, ry, 1'($urandom),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 4) == 0), wa, 16'($urandom));
            chk_model("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
